// File: rtl/fpdiv_pkg.sv
// Shared types for the FP32 divider result stage: field view of an FP32 word,
// FSM states, exception flags and the IEEE-754 exception fix-up.
package fpdiv_pkg;

  localparam logic [7:0] FP32_INF_EXP = 8'hFF;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {IDLE, WAIT, CAPT} state_t;

  typedef struct packed {
    logic ovf;
    logic unf;
  } flags_t;

  typedef struct packed {
    fp32_t  result;
    flags_t flags;
  } entry_t;

  // Overflow saturates to signed infinity, underflow flushes to signed zero;
  // overflow takes priority when the divider raises both.
  function automatic entry_t fixup(input fp32_t raw, input logic ovf, input logic unf);
    entry_t e;
    e.result = raw;
    e.flags  = '0;
    if (ovf) begin
      e.result = '{sign: raw.sign, exp: FP32_INF_EXP, frac: '0};
      e.flags.ovf = 1'b1;
    end else if (unf) begin
      e.result = '{sign: raw.sign, exp: '0, frac: '0};
      e.flags.unf = 1'b1;
    end
    return e;
  endfunction

endpackage

// File: rtl/fpdiv_out_fifo.sv
// Small register-based output FIFO; the head entry is read straight from storage.
module fpdiv_out_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 34
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: storage is reset too, so out_result reads 0 after reset rather than X.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fpdiv_result_stage.sv
// Sequences one operand pair at a time through the combinational FP32 divider,
// fixes up exceptional results and queues them for the consumer.
module fpdiv_result_stage
  import fpdiv_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_A,
  input  logic [31:0] in_B,
  output logic [31:0] div_A,
  output logic [31:0] div_B,
  input  logic [31:0] div_result,
  input  logic        div_overflow,
  input  logic        div_underflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [1:0]  out_flags,
  output logic        sticky_ovf,
  output logic        sticky_unf,
  input  logic        clr_sticky,
  output logic        busy
);

  localparam int CNT_W  = $clog2(LAT+1);
  localparam int FCNT_W = $clog2(DEPTH+1);

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                accept;
  logic                capt;
  entry_t              fixed;
  entry_t              head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FCNT_W-1:0]   fifo_count;

  assign accept = in_valid && in_ready;
  assign fixed  = fixup(div_result, div_overflow, div_underflow);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = (LAT == 1) ? CAPT : WAIT;
      WAIT: if (cnt == CNT_W'(1)) state_nxt = CAPT;
      CAPT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    capt     = 1'b0;
    busy     = (state != IDLE);
    unique case (state)
      IDLE:    in_ready = !RST && (fifo_count < FCNT_W'(DEPTH));
      CAPT:    capt = 1'b1;
      default: ;
    endcase
  end

  // Operands stay on div_A/div_B until the next accept so the divider output
  // is settled by the capture edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= '0;
      div_A <= '0;
      div_B <= '0;
    end else if (accept) begin
      cnt   <= CNT_W'(LAT-1);
      div_A <= in_A;
      div_B <= in_B;
    end else if (state == WAIT) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
    end else begin
      if (capt && fixed.flags.ovf) sticky_ovf <= 1'b1;
      else if (clr_sticky)         sticky_ovf <= 1'b0;
      if (capt && fixed.flags.unf) sticky_unf <= 1'b1;
      else if (clr_sticky)         sticky_unf <= 1'b0;
    end
  end

  fpdiv_out_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (capt && !fifo_full),
    .push_data (fixed),
    .pop       (out_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid  = !fifo_empty;
  assign out_result = head.result;
  assign out_flags  = head.flags;

endmodule

// File: tb/tb_fpdiv_result_stage.sv
// Directed bench for fpdiv_result_stage with a table-driven stub divider.
module tb_fpdiv_result_stage;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_A;
  logic [31:0] in_B;
  logic [31:0] div_A;
  logic [31:0] div_B;
  logic [31:0] div_result;
  logic        div_overflow;
  logic        div_underflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [1:0]  out_flags;
  logic        sticky_ovf;
  logic        sticky_unf;
  logic        clr_sticky;
  logic        busy;

  int tests = 0;
  int fails = 0;

  fpdiv_result_stage #(.LAT(2), .DEPTH(2)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_A          (in_A),
    .in_B          (in_B),
    .div_A         (div_A),
    .div_B         (div_B),
    .div_result    (div_result),
    .div_overflow  (div_overflow),
    .div_underflow (div_underflow),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_flags     (out_flags),
    .sticky_ovf    (sticky_ovf),
    .sticky_unf    (sticky_unf),
    .clr_sticky    (clr_sticky),
    .busy          (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Combinational divider stand-in: raw results for the operand pairs used here.
  // Raw results on exception paths are deliberately not the fixed-up values.
  always_comb begin
    div_result    = 32'h0;
    div_overflow  = 1'b0;
    div_underflow = 1'b0;
    case ({div_A, div_B})
      {32'h40C00000, 32'h40000000}: div_result = 32'h40400000;  // 6/2 = 3
      {32'h40800000, 32'h3F800000}: div_result = 32'h40800000;  // 4/1 = 4
      {32'h41000000, 32'h40000000}: div_result = 32'h40800000;  // 8/2 = 4
      {32'h7F000000, 32'h00800000}: begin div_result = 32'h7F7FFFFF; div_overflow = 1'b1; end
      {32'h00800000, 32'h7F000000}: begin div_result = 32'h00000001; div_underflow = 1'b1; end
      {32'h80800000, 32'h7F000000}: begin div_result = 32'h80000001; div_underflow = 1'b1; end
      {32'hFF000000, 32'h00800000}: begin
        div_result = 32'hC0000000; div_overflow = 1'b1; div_underflow = 1'b1;
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic [1:0]  exp_flags;
    logic [1:0]  exp_sticky;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 20 && !in_ready; i++) step();
    check(name, in_ready, 1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && busy; i++) step();
    check(name, busy, 0);
  endtask

  task automatic wait_out(input string name);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    check(name, out_valid, 1);
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    in_A = a;
    in_B = b;
    in_valid = 1'b1;
    wait_ready("launch_ready");
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 2'b00, 2'b00};
    vecs[1] = '{32'h40800000, 32'h3F800000, 32'h40800000, 2'b00, 2'b00};
    vecs[2] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 2'b10, 2'b10};
    vecs[3] = '{32'h00800000, 32'h7F000000, 32'h00000000, 2'b01, 2'b11};
    vecs[4] = '{32'h80800000, 32'h7F000000, 32'h80000000, 2'b01, 2'b11};
    vecs[5] = '{32'hFF000000, 32'h00800000, 32'hFF800000, 2'b10, 2'b11};

    RST = 1'b1; in_valid = 1'b0; in_A = '0; in_B = '0;
    out_ready = 1'b0; clr_sticky = 1'b0;
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sticky", {sticky_ovf, sticky_unf}, 0);
    check("rst_div_A", div_A, 0);
    check("rst_out_result", out_result, 0);
    RST = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Basic op with exact latency: capture edge is two edges after accept.
    out_ready = 1'b1;
    launch(32'h40C00000, 32'h40000000);
    check("t1_div_A", div_A, 32'h40C00000);
    check("t1_div_B", div_B, 32'h40000000);
    check("t1_busy_wait", busy, 1);
    check("t1_no_out_wait", out_valid, 0);
    check("t1_in_ready_wait", in_ready, 0);
    step();
    check("t1_busy_capt", busy, 1);
    check("t1_no_out_capt", out_valid, 0);
    step();
    check("t1_out_valid", out_valid, 1);
    check("t1_result", out_result, 32'h40400000);
    check("t1_flags", out_flags, 2'b00);
    check("t1_idle", busy, 0);
    step();
    check("t1_popped", out_valid, 0);

    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].a, vecs[i].b);
      wait_out("vec_out_valid");
      check($sformatf("vec%0d_result", i), out_result, vecs[i].exp_result);
      check($sformatf("vec%0d_flags", i), out_flags, vecs[i].exp_flags);
      check($sformatf("vec%0d_sticky", i), {sticky_ovf, sticky_unf}, vecs[i].exp_sticky);
      step();
      check($sformatf("vec%0d_popped", i), out_valid, 0);
    end

    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("clr_sticky", {sticky_ovf, sticky_unf}, 2'b00);

    // Backpressure: two ops fill the FIFO, the third waits for a pop.
    out_ready = 1'b0;
    in_A = 32'h40800000; in_B = 32'h3F800000; in_valid = 1'b1;
    wait_ready("t4_ready_op1");
    step();
    in_A = 32'h40C00000; in_B = 32'h40000000;
    wait_ready("t4_ready_op2");
    step();
    in_A = 32'h41000000; in_B = 32'h40000000;
    wait_idle("t4_idle_op2");
    check("t4_full_in_ready", in_ready, 0);
    check("t4_head_op1", out_result, 32'h40800000);
    step();
    step();
    step();
    check("t4_in_ready_held", in_ready, 0);
    check("t4_busy_held", busy, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t4_head_op2", out_result, 32'h40400000);
    check("t4_in_ready_back", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t4_op3_accepted", div_A, 32'h41000000);
    wait_idle("t4_idle_op3");
    check("t4_head_still_op2", out_result, 32'h40400000);
    out_ready = 1'b1;
    step();
    check("t4_head_op3", out_result, 32'h40800000);
    check("t4_op3_valid", out_valid, 1);
    step();
    check("t4_drained", out_valid, 0);

    // Reset while an op sits in WAIT: it must vanish without output.
    launch(32'h7F000000, 32'h00800000);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_out_valid", out_valid, 0);
    check("t5_div_A", div_A, 0);
    step();
    step();
    step();
    check("t5_no_late_out", out_valid, 0);
    check("t5_no_sticky", sticky_ovf, 0);
    launch(32'h41000000, 32'h40000000);
    wait_out("t5_out_valid_after");
    check("t5_result_after", out_result, 32'h40800000);
    step();

    // Set beats clear on the capture edge.
    launch(32'h7F000000, 32'h00800000);
    step();
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("t6_set_wins", sticky_ovf, 1);
    check("t6_flags", out_flags, 2'b10);
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("t6_cleared", sticky_ovf, 0);
    check("t6_popped", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
